// File: rtl/cpu_mem_arbiter_pkg.sv
// cpu_mem_arbiter_pkg: shared state and port types for the CPU memory arbiter.
package cpu_mem_arbiter_pkg;
    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} arb_state_t;
    typedef enum logic {PORT_I, PORT_D} arb_port_t;
endpackage

// File: rtl/cpu_mem_arbiter_control.sv
// cpu_mem_arbiter_control: round-robin grant FSM serialising the I and D ports onto pmem.
module cpu_mem_arbiter_control
    import cpu_mem_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      i_req,
    input  logic      d_req,
    input  logic      pmem_resp,
    output arb_port_t grant,
    output logic      load,
    output logic      busy,
    output logic      latch_i,
    output logic      latch_d,
    output logic      i_resp,
    output logic      d_resp
);
    arb_state_t state, state_next;
    arb_port_t  last_grant;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= PORT_I;
        end else begin
            state <= state_next;
            if (load) last_grant <= grant;
        end
    end
    always_comb begin
        grant      = (i_req && d_req) ? ((last_grant == PORT_I) ? PORT_D : PORT_I)
                                      : (d_req ? PORT_D : PORT_I);
        load       = (state == IDLE) && (i_req || d_req);
        busy       = (state == BUSY_I) || (state == BUSY_D);
        latch_i    = (state == BUSY_I) && pmem_resp;
        latch_d    = (state == BUSY_D) && pmem_resp;
        i_resp     = state == DONE_I;
        d_resp     = state == DONE_D;
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = (grant == PORT_D) ? BUSY_D : BUSY_I;
            BUSY_I:  if (pmem_resp) state_next = DONE_I;
            BUSY_D:  if (pmem_resp) state_next = DONE_D;
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: captures the granted CPU request and replays it on the shared pmem port.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] i_mem_address,
    input  logic [DATA_WIDTH-1:0] i_mem_wdata,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [1:0]            i_mem_byte_enable,
    output logic                  i_mem_resp,
    output logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic [ADDR_WIDTH-1:0] d_mem_address,
    input  logic [DATA_WIDTH-1:0] d_mem_wdata,
    input  logic                  d_mem_read,
    input  logic                  d_mem_write,
    input  logic [1:0]            d_mem_byte_enable,
    output logic                  d_mem_resp,
    output logic [DATA_WIDTH-1:0] d_mem_rdata,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [DATA_WIDTH-1:0] pmem_wdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [1:0]            pmem_byte_enable,
    input  logic                  pmem_resp,
    input  logic [DATA_WIDTH-1:0] pmem_rdata
);
    arb_port_t grant;
    logic      load, busy, latch_i, latch_d, cap_write, sel_d;
    cpu_mem_arbiter_control u_control (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_mem_read | i_mem_write),
        .d_req     (d_mem_read | d_mem_write),
        .pmem_resp (pmem_resp),
        .grant     (grant),
        .load      (load),
        .busy      (busy),
        .latch_i   (latch_i),
        .latch_d   (latch_d),
        .i_resp    (i_mem_resp),
        .d_resp    (d_mem_resp)
    );
    assign sel_d      = grant == PORT_D;
    // Write wins when a port raises read and write together.
    assign pmem_read  = busy && !cap_write;
    assign pmem_write = busy && cap_write;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pmem_address     <= '0;
            pmem_wdata       <= '0;
            pmem_byte_enable <= '0;
            cap_write        <= 1'b0;
            i_mem_rdata      <= '0;
            d_mem_rdata      <= '0;
        end else begin
            if (load) begin
                pmem_address     <= sel_d ? d_mem_address : i_mem_address;
                pmem_wdata       <= sel_d ? d_mem_wdata : i_mem_wdata;
                pmem_byte_enable <= sel_d ? d_mem_byte_enable : i_mem_byte_enable;
                cap_write        <= sel_d ? d_mem_write : i_mem_write;
            end
            if (latch_i && !cap_write) i_mem_rdata <= pmem_rdata;
            if (latch_d && !cap_write) d_mem_rdata <= pmem_rdata;
        end
    end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed scoreboard bench for the CPU memory arbiter.
module tb_cpu_mem_arbiter;
    typedef struct {
        logic        port;
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [1:0]  be;
    } exp_t;

    logic        clk = 0;
    logic        reset;
    logic [15:0] i_mem_address, i_mem_wdata, i_mem_rdata;
    logic        i_mem_read, i_mem_write, i_mem_resp;
    logic [1:0]  i_mem_byte_enable;
    logic [15:0] d_mem_address, d_mem_wdata, d_mem_rdata;
    logic        d_mem_read, d_mem_write, d_mem_resp;
    logic [1:0]  d_mem_byte_enable;
    logic [15:0] pmem_address, pmem_wdata, pmem_rdata;
    logic        pmem_read, pmem_write, pmem_resp;
    logic [1:0]  pmem_byte_enable;

    exp_t        q[$];
    logic [15:0] i_model = 0, d_model = 0;
    int          checks = 0, fails = 0, cyc = 0, done_cyc = 0, prev_done = 0;

    cpu_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .i_mem_address     (i_mem_address),
        .i_mem_wdata       (i_mem_wdata),
        .i_mem_read        (i_mem_read),
        .i_mem_write       (i_mem_write),
        .i_mem_byte_enable (i_mem_byte_enable),
        .i_mem_resp        (i_mem_resp),
        .i_mem_rdata       (i_mem_rdata),
        .d_mem_address     (d_mem_address),
        .d_mem_wdata       (d_mem_wdata),
        .d_mem_read        (d_mem_read),
        .d_mem_write       (d_mem_write),
        .d_mem_byte_enable (d_mem_byte_enable),
        .d_mem_resp        (d_mem_resp),
        .d_mem_rdata       (d_mem_rdata),
        .pmem_address      (pmem_address),
        .pmem_wdata        (pmem_wdata),
        .pmem_read         (pmem_read),
        .pmem_write        (pmem_write),
        .pmem_byte_enable  (pmem_byte_enable),
        .pmem_resp         (pmem_resp),
        .pmem_rdata        (pmem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic port, input logic [15:0] addr, input logic we,
                        input logic [15:0] wdata, input logic [1:0] be);
        exp_t e;
        e.port = port; e.addr = addr; e.we = we; e.wdata = wdata; e.be = be;
        q.push_back(e);
    endtask

    // Waits for the next pmem strobe, checks it against the scoreboard head,
    // answers after `delay` extra BUSY cycles and checks the DONE cycle.
    task automatic transact(input int delay, input logic [15:0] rd, input bit scramble);
        exp_t e;
        bit   seen = 0;
        for (int n = 0; n < 12 && !seen; n++) begin
            step();
            chk("no_early_resp", 32'({i_mem_resp, d_mem_resp}), 32'd0);
            chk("i_rdata_hold", 32'(i_mem_rdata), 32'(i_model));
            chk("d_rdata_hold", 32'(d_mem_rdata), 32'(d_model));
            seen = pmem_read || pmem_write;
        end
        chk("strobe_seen", 32'(seen), 32'd1);
        if (!seen) return;
        chk("queue_has_entry", 32'(q.size() > 0), 32'd1);
        if (q.size() == 0) return;
        e = q.pop_front();
        chk("pmem_address", 32'(pmem_address), 32'(e.addr));
        chk("pmem_write", 32'(pmem_write), 32'(e.we));
        chk("pmem_read", 32'(pmem_read), 32'(!e.we));
        chk("pmem_byte_enable", 32'(pmem_byte_enable), 32'(e.be));
        if (e.we) chk("pmem_wdata", 32'(pmem_wdata), 32'(e.wdata));
        for (int n = 0; n < delay; n++) begin
            if (scramble) begin
                i_mem_address = 16'($urandom);
                d_mem_address = 16'($urandom);
            end
            step();
            chk("hold_address", 32'(pmem_address), 32'(e.addr));
            chk("hold_strobe", 32'(pmem_read | pmem_write), 32'd1);
            chk("busy_no_resp", 32'({i_mem_resp, d_mem_resp}), 32'd0);
        end
        pmem_resp  = 1;
        pmem_rdata = rd;
        step();
        pmem_resp  = 0;
        pmem_rdata = 16'($urandom);
        if (!e.we) begin
            if (e.port) d_model = rd;
            else i_model = rd;
        end
        chk("i_resp", 32'(i_mem_resp), 32'(!e.port));
        chk("d_resp", 32'(d_mem_resp), 32'(e.port));
        chk("i_rdata", 32'(i_mem_rdata), 32'(i_model));
        chk("d_rdata", 32'(d_mem_rdata), 32'(d_model));
        chk("done_no_strobe", 32'(pmem_read | pmem_write), 32'd0);
        done_cyc = cyc;
    endtask

    initial begin
        bit seen;
        reset = 1; pmem_resp = 0; pmem_rdata = 0;
        i_mem_address = 0; i_mem_wdata = 0; i_mem_read = 0; i_mem_write = 0; i_mem_byte_enable = 0;
        d_mem_address = 16'h2000; d_mem_wdata = 0; d_mem_read = 1; d_mem_write = 0;
        d_mem_byte_enable = 2'b11;
        step(); step();
        chk("rst_pmem_read", 32'(pmem_read), 32'd0);
        chk("rst_pmem_write", 32'(pmem_write), 32'd0);
        chk("rst_pmem_address", 32'(pmem_address), 32'd0);
        chk("rst_i_rdata", 32'(i_mem_rdata), 32'd0);
        chk("rst_d_rdata", 32'(d_mem_rdata), 32'd0);
        chk("rst_resps", 32'({i_mem_resp, d_mem_resp}), 32'd0);

        // First grant after reset goes to D
        push(1, 16'h2000, 0, 0, 2'b11);
        reset = 0;
        transact(0, 16'h1234, 0);
        d_mem_read = 0;

        // Constant instruction fetch: one pulse every 4 cycles
        i_mem_read = 1; i_mem_address = 16'h0040; i_mem_byte_enable = 2'b11;
        for (int k = 0; k < 3; k++) begin
            push(0, 16'h0040, 0, 0, 2'b11);
            prev_done = done_cyc;
            transact(1, 16'hA000 + 16'(k), 0);
            if (k > 0) chk("fetch_period", 32'(done_cyc - prev_done), 32'd4);
        end

        // Both ports continuously requesting: D, I, D, I
        d_mem_read = 1; d_mem_address = 16'h3000; d_mem_byte_enable = 2'b11;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push(1, 16'h3000, 0, 0, 2'b11);
            else push(0, 16'h0040, 0, 0, 2'b11);
            transact(1, 16'hB000 + 16'(k), 0);
        end
        i_mem_read = 0; d_mem_read = 0;

        // Data write leaves d_mem_rdata untouched
        d_mem_write = 1; d_mem_address = 16'h0100; d_mem_wdata = 16'hBEEF; d_mem_byte_enable = 2'b01;
        push(1, 16'h0100, 1, 16'hBEEF, 2'b01);
        transact(2, 16'hDEAD, 0);
        d_mem_write = 0;

        // Read and write together behave as a write
        i_mem_read = 1; i_mem_write = 1; i_mem_address = 16'h0200;
        i_mem_wdata = 16'h5A5A; i_mem_byte_enable = 2'b10;
        push(0, 16'h0200, 1, 16'h5A5A, 2'b10);
        transact(0, 16'h7777, 0);
        i_mem_read = 0; i_mem_write = 0;

        // Address changes during a long BUSY_I are ignored
        i_mem_read = 1; i_mem_address = 16'h0500; i_mem_byte_enable = 2'b11;
        push(0, 16'h0500, 0, 0, 2'b11);
        transact(5, 16'h4242, 1);
        i_mem_read = 0;

        // Async reset in BUSY_D abandons the transaction
        d_mem_read = 1; d_mem_address = 16'h0700; d_mem_byte_enable = 2'b11;
        seen = 0;
        for (int n = 0; n < 12 && !seen; n++) begin
            step();
            seen = pmem_read;
        end
        chk("busy_d_reached", 32'(seen), 32'd1);
        chk("busy_d_address", 32'(pmem_address), 32'h0700);
        #3 reset = 1;
        #1;
        chk("async_rst_read", 32'(pmem_read), 32'd0);
        chk("async_rst_address", 32'(pmem_address), 32'd0);
        chk("async_rst_d_rdata", 32'(d_mem_rdata), 32'd0);
        chk("async_rst_i_rdata", 32'(i_mem_rdata), 32'd0);
        i_model = 0; d_model = 0;
        d_mem_read = 0;
        step();
        reset = 0;
        pmem_resp = 1; pmem_rdata = 16'hFFFF;
        for (int n = 0; n < 3; n++) begin
            step();
            pmem_resp = 0;
            chk("post_rst_no_resp", 32'({i_mem_resp, d_mem_resp}), 32'd0);
            chk("post_rst_no_strobe", 32'(pmem_read | pmem_write), 32'd0);
            chk("post_rst_d_rdata", 32'(d_mem_rdata), 32'(d_model));
        end
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
Memory-side responder for the CPU's split instruction and data ports. It accepts held requests on the i_mem and d_mem ports and serialises them onto a single shared physical memory port. Each grant completes with a one-cycle resp pulse and latched rdata. It sits between cpu_datapath and the shared memory or L2.

Parameters:
ADDR_WIDTH, 16, width of all address buses.
DATA_WIDTH, 16, width of all data buses (2 byte lanes).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
i_mem_address  in  ADDR_WIDTH  instruction request address.
i_mem_wdata  in  DATA_WIDTH  instruction write data (normally 0).
i_mem_read  in  1  instruction read request, held until resp.
i_mem_write  in  1  instruction write request, held until resp.
i_mem_byte_enable  in  2  instruction byte lanes.
i_mem_resp  out  1  one-cycle completion pulse, instruction port.
i_mem_rdata  out  DATA_WIDTH  instruction read data, valid while i_mem_resp=1.
d_mem_address, d_mem_wdata, d_mem_read, d_mem_write, d_mem_byte_enable  in  as i_mem_*  data request.
d_mem_resp  out  1  one-cycle completion pulse, data port.
d_mem_rdata  out  DATA_WIDTH  data read data, valid while d_mem_resp=1.
pmem_address  out  ADDR_WIDTH  shared-port address.
pmem_wdata  out  DATA_WIDTH  shared-port write data.
pmem_read  out  1  shared-port read strobe, held until pmem_resp.
pmem_write  out  1  shared-port write strobe, held until pmem_resp.
pmem_byte_enable  out  2  shared-port byte lanes.
pmem_resp  in  1  shared-port completion, one-cycle pulse.
pmem_rdata  in  DATA_WIDTH  shared-port read data, valid with pmem_resp.

Behaviour:
- Reset (async): state IDLE, last_grant=I. All outputs, capture registers and rdata registers are 0. A pending pmem transaction is abandoned and no resp is issued.
- A port request is pending when read|write=1. If read and write are both asserted, the request is treated as a write.
- FSM states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE:
  - If only one port is pending, grant it.
  - If both are pending, grant the port opposite last_grant (round robin).
  - On grant, capture address, wdata, byte_enable and op into registers; set last_grant; go to BUSY_x.
  - No pmem strobes in IDLE.
- BUSY_x:
  - pmem_* driven from the capture registers; pmem_read or pmem_write stays asserted until pmem_resp.
  - Later changes on the CPU inputs are ignored.
  - On pmem_resp: latch pmem_rdata into x_rdata (reads only; writes leave it unchanged); go to DONE_x.
- DONE_x: x_mem_resp=1 for exactly this cycle; pmem strobes are 0; next state is IDLE.
- Latency: request sampled at edge k, then BUSY at k+1. If pmem_resp arrives in the first BUSY cycle, resp is high in cycle k+2. Total = 2 + pmem wait cycles.
- A request still asserted in the IDLE cycle after DONE is a new request. A constant i_mem_read=1 therefore yields back-to-back fetches every ≥3 cycles.
- x_mem_rdata holds its last latched value between responses.
- No starvation: with both ports continuously requesting, grants alternate I, D, I, D.
- pmem_resp outside BUSY is ignored.

Decomposition:
- lc3b_types gains: enum arb_state_t {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D}; enum arb_port_t {PORT_I, PORT_D}.
- Natural split into two modules:
  - arbiter_control: FSM, last_grant, grant and load signals.
  - cpu_mem_arbiter top: capture registers, rdata registers, output muxes.
- The existing register and mux2 modules are reused for captures and muxing.

Test Plan:
- Reset with d_mem_read=1 held → after deassert, first grant goes to D. pmem_address equals d_mem_address from cycle 1. pmem_resp with rdata=16'h1234 → d_mem_rdata=16'h1234 and d_mem_resp=1 for one cycle. i_mem_resp stays 0.
- i_mem_read=1 constantly at address 16'h0040, pmem_resp one cycle after each strobe → i_mem_resp pulses exactly every 4 cycles, never two consecutive cycles.
- Both ports requesting continuously → grant order D, I, D, I over 4 transactions; pmem_address alternates between the d and i addresses.
- d_mem_write=1, address 16'h0100, wdata 16'hBEEF, byte_enable 2'b01 → pmem_write=1 with identical address, data and lanes. d_mem_rdata is unchanged and d_mem_resp pulses once.
- Change i_mem_address during BUSY_I while pmem_resp is delayed 5 cycles → pmem_address stays at the captured value throughout.
- Assert reset in BUSY_D → pmem_read falls to 0 asynchronously and no d_mem_resp occurs. pmem_resp arriving after reset is ignored.
